// File: rtl/video_pkg.sv
// Shared types and constants for the video Wishbone arbiter.
package video_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1,
        StAbort
    } arb_state_t;

    localparam logic [1:0] GntNone = 2'b00;
    localparam logic [1:0] GntM0   = 2'b01;
    localparam logic [1:0] GntM1   = 2'b10;

    localparam int unsigned DefaultTimeout = 255;

    function automatic logic [1:0] state_grant(arb_state_t s);
        case (s)
            StOwn0:  return GntM0;
            StOwn1:  return GntM1;
            default: return GntNone;
        endcase
    endfunction

endpackage

// File: rtl/video_wb_watchdog.sv
// Counts cycles a granted strobe waits for a response; expired_o flags the
// cycle on whose closing edge the count would reach Timeout.
module video_wb_watchdog
    import video_pkg::*;
#(
    parameter int unsigned Timeout = DefaultTimeout
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strobe_i,
    input  logic done_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned     CntW   = (Timeout > 0) ? $clog2(Timeout + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Timeout);

    logic [CntW-1:0] cnt_q, cnt_d;

    // A response in the threshold cycle wins: done_i clears and suppresses expiry.
    always_comb begin
        cnt_d     = '0;
        expired_o = 1'b0;
        if (Timeout != 0 && enable_i && strobe_i && !done_i) begin
            cnt_d     = cnt_q + 1'b1;
            expired_o = (cnt_d == CntMax);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/video_wb_arbiter.sv
// Two-master Wishbone arbiter (video_in store / video_out fetch) onto one slave,
// round-robin with bus lock and a watchdog that aborts unanswered strobes.
module video_wb_arbiter
    import video_pkg::*;
#(
    parameter int unsigned TIMEOUT    = DefaultTimeout,
    parameter int unsigned FIRST_PRIO = 0
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        m0_wb_CYC_I,
    input  logic        m0_wb_STB_I,
    input  logic        m0_wb_LOCK_I,
    input  logic        m0_wb_WE_I,
    input  logic [3:0]  m0_wb_SEL_I,
    input  logic [31:0] m0_wb_ADR_I,
    input  logic [31:0] m0_wb_DAT_I,
    output logic        m0_wb_ACK_O,
    output logic        m0_wb_ERR_O,
    output logic [31:0] m0_wb_DAT_O,
    input  logic        m1_wb_CYC_I,
    input  logic        m1_wb_STB_I,
    input  logic        m1_wb_LOCK_I,
    input  logic        m1_wb_WE_I,
    input  logic [3:0]  m1_wb_SEL_I,
    input  logic [31:0] m1_wb_ADR_I,
    input  logic [31:0] m1_wb_DAT_I,
    output logic        m1_wb_ACK_O,
    output logic        m1_wb_ERR_O,
    output logic [31:0] m1_wb_DAT_O,
    output logic        s_wb_CYC_O,
    output logic        s_wb_STB_O,
    output logic        s_wb_LOCK_O,
    output logic        s_wb_WE_O,
    output logic [3:0]  s_wb_SEL_O,
    output logic [31:0] s_wb_ADR_O,
    output logic [31:0] s_wb_DAT_O,
    input  logic        s_wb_ACK_I,
    input  logic        s_wb_ERR_I,
    input  logic [31:0] s_wb_DAT_I,
    output logic [1:0]  grant,
    output logic        timeout_irq
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;       // 1: master 1 held the bus most recently
    logic       abort_m_q, abort_m_d; // master that was aborted
    logic [1:0] grant_q;
    logic       irq_q;
    logic       expired;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        abort_m_d = abort_m_q;
        unique case (state_q)
            StIdle: begin
                if (m0_wb_CYC_I && m1_wb_CYC_I) state_d = last_q ? StOwn0 : StOwn1;
                else if (m0_wb_CYC_I)           state_d = StOwn0;
                else if (m1_wb_CYC_I)           state_d = StOwn1;
            end
            StOwn0: begin
                if (expired) begin
                    state_d   = StAbort;
                    abort_m_d = 1'b0;
                end else if (!m0_wb_CYC_I && !m0_wb_LOCK_I) begin
                    state_d = m1_wb_CYC_I ? StOwn1 : StIdle;
                end
            end
            StOwn1: begin
                if (expired) begin
                    state_d   = StAbort;
                    abort_m_d = 1'b1;
                end else if (!m1_wb_CYC_I && !m1_wb_LOCK_I) begin
                    state_d = m0_wb_CYC_I ? StOwn0 : StIdle;
                end
            end
            StAbort: begin
                if (abort_m_q && !m1_wb_CYC_I) begin
                    state_d = m0_wb_CYC_I ? StOwn0 : StIdle;
                end else if (!abort_m_q && !m0_wb_CYC_I) begin
                    state_d = m1_wb_CYC_I ? StOwn1 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StOwn0) last_d = 1'b0;
        if (state_d == StOwn1) last_d = 1'b1;
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            last_q    <= (FIRST_PRIO == 0);
            abort_m_q <= 1'b0;
            grant_q   <= GntNone;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            abort_m_q <= abort_m_d;
            grant_q   <= state_grant(state_d);
            irq_q     <= (state_d == StAbort) && (state_q != StAbort);
        end
    end

    video_wb_watchdog #(
        .Timeout (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk),
        .rst_i     (RST),
        .strobe_i  ((state_q == StOwn1) ? m1_wb_STB_I : m0_wb_STB_I),
        .done_i    (s_wb_ACK_I | s_wb_ERR_I),
        .enable_i  ((state_q == StOwn0) || (state_q == StOwn1)),
        .expired_o (expired)
    );

    always_comb begin
        s_wb_CYC_O  = 1'b0;
        s_wb_STB_O  = 1'b0;
        s_wb_LOCK_O = 1'b0;
        s_wb_WE_O   = 1'b0;
        s_wb_SEL_O  = '0;
        s_wb_ADR_O  = '0;
        s_wb_DAT_O  = '0;
        m0_wb_ACK_O = 1'b0;
        m0_wb_ERR_O = 1'b0;
        m0_wb_DAT_O = '0;
        m1_wb_ACK_O = 1'b0;
        m1_wb_ERR_O = 1'b0;
        m1_wb_DAT_O = '0;
        unique case (state_q)
            StOwn0: begin
                s_wb_CYC_O  = m0_wb_CYC_I;
                s_wb_STB_O  = m0_wb_STB_I;
                s_wb_LOCK_O = m0_wb_LOCK_I;
                s_wb_WE_O   = m0_wb_WE_I;
                s_wb_SEL_O  = m0_wb_SEL_I;
                s_wb_ADR_O  = m0_wb_ADR_I;
                s_wb_DAT_O  = m0_wb_DAT_I;
                m0_wb_ACK_O = s_wb_ACK_I;
                m0_wb_ERR_O = s_wb_ERR_I;
                m0_wb_DAT_O = s_wb_DAT_I;
            end
            StOwn1: begin
                s_wb_CYC_O  = m1_wb_CYC_I;
                s_wb_STB_O  = m1_wb_STB_I;
                s_wb_LOCK_O = m1_wb_LOCK_I;
                s_wb_WE_O   = m1_wb_WE_I;
                s_wb_SEL_O  = m1_wb_SEL_I;
                s_wb_ADR_O  = m1_wb_ADR_I;
                s_wb_DAT_O  = m1_wb_DAT_I;
                m1_wb_ACK_O = s_wb_ACK_I;
                m1_wb_ERR_O = s_wb_ERR_I;
                m1_wb_DAT_O = s_wb_DAT_I;
            end
            default: ;
        endcase
        // irq_q is high only in the first ABORT cycle: one-shot error to the victim.
        if (irq_q) begin
            if (abort_m_q) m1_wb_ERR_O = 1'b1;
            else           m0_wb_ERR_O = 1'b1;
        end
    end

    assign grant       = grant_q;
    assign timeout_irq = irq_q;

endmodule

// File: tb/tb_video_wb_arbiter.sv
// Scoreboard bench for video_wb_arbiter: per-cycle expected outputs are queued
// by the driver and checked by an independent negedge monitor.
module tb_video_wb_arbiter;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;
    localparam logic [31:0] D0 = 32'hA0A0_0000;
    localparam logic [31:0] D1 = 32'hB1B1_0000;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        m0_wb_CYC_I = 0, m0_wb_STB_I = 0, m0_wb_LOCK_I = 0;
    logic        m1_wb_CYC_I = 0, m1_wb_STB_I = 0, m1_wb_LOCK_I = 0;
    logic        s_wb_ACK_I = 0, s_wb_ERR_I = 0;
    logic [31:0] s_wb_DAT_I = '0;
    logic        m0_wb_ACK_O, m0_wb_ERR_O, m1_wb_ACK_O, m1_wb_ERR_O;
    logic [31:0] m0_wb_DAT_O, m1_wb_DAT_O;
    logic        s_wb_CYC_O, s_wb_STB_O, s_wb_LOCK_O, s_wb_WE_O;
    logic [3:0]  s_wb_SEL_O;
    logic [31:0] s_wb_ADR_O, s_wb_DAT_O;
    logic [1:0]  grant;
    logic        timeout_irq;

    always #5 clk = ~clk;

    video_wb_arbiter #(
        .TIMEOUT    (4),
        .FIRST_PRIO (0)
    ) dut (
        .clk          (clk),
        .RST          (RST),
        .m0_wb_CYC_I  (m0_wb_CYC_I),
        .m0_wb_STB_I  (m0_wb_STB_I),
        .m0_wb_LOCK_I (m0_wb_LOCK_I),
        .m0_wb_WE_I   (1'b1),
        .m0_wb_SEL_I  (4'hF),
        .m0_wb_ADR_I  (A0),
        .m0_wb_DAT_I  (D0),
        .m0_wb_ACK_O  (m0_wb_ACK_O),
        .m0_wb_ERR_O  (m0_wb_ERR_O),
        .m0_wb_DAT_O  (m0_wb_DAT_O),
        .m1_wb_CYC_I  (m1_wb_CYC_I),
        .m1_wb_STB_I  (m1_wb_STB_I),
        .m1_wb_LOCK_I (m1_wb_LOCK_I),
        .m1_wb_WE_I   (1'b0),
        .m1_wb_SEL_I  (4'h3),
        .m1_wb_ADR_I  (A1),
        .m1_wb_DAT_I  (D1),
        .m1_wb_ACK_O  (m1_wb_ACK_O),
        .m1_wb_ERR_O  (m1_wb_ERR_O),
        .m1_wb_DAT_O  (m1_wb_DAT_O),
        .s_wb_CYC_O   (s_wb_CYC_O),
        .s_wb_STB_O   (s_wb_STB_O),
        .s_wb_LOCK_O  (s_wb_LOCK_O),
        .s_wb_WE_O    (s_wb_WE_O),
        .s_wb_SEL_O   (s_wb_SEL_O),
        .s_wb_ADR_O   (s_wb_ADR_O),
        .s_wb_DAT_O   (s_wb_DAT_O),
        .s_wb_ACK_I   (s_wb_ACK_I),
        .s_wb_ERR_I   (s_wb_ERR_I),
        .s_wb_DAT_I   (s_wb_DAT_I),
        .grant        (grant),
        .timeout_irq  (timeout_irq)
    );

    typedef struct packed {
        logic [1:0]  gnt;
        logic        scyc, sstb, slock, swe;
        logic [31:0] sadr, sdato;
        logic        a0, a1, e0, e1, irq;
        logic [31:0] d0, d1;
    } obs_t;

    obs_t  exp_q[$];
    string nm_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    // One cycle of stimulus plus the outputs expected in that same cycle.
    task automatic v(input string nm, input logic rst,
                     input logic c0, input logic s0, input logic l0,
                     input logic c1, input logic s1, input logic l1,
                     input logic ack, input logic err, input logic [31:0] sdat,
                     input logic [1:0] gnt, input logic a0, input logic a1,
                     input logic e0, input logic e1, input logic irq);
        obs_t e;
        logic o0, o1;
        @(posedge clk);
        #1;
        RST = rst;
        m0_wb_CYC_I = c0; m0_wb_STB_I = s0; m0_wb_LOCK_I = l0;
        m1_wb_CYC_I = c1; m1_wb_STB_I = s1; m1_wb_LOCK_I = l1;
        s_wb_ACK_I = ack; s_wb_ERR_I = err; s_wb_DAT_I = sdat;
        o0 = (gnt == 2'b01);
        o1 = (gnt == 2'b10);
        e.gnt   = gnt;
        e.scyc  = o0 ? c0 : (o1 ? c1 : 1'b0);
        e.sstb  = o0 ? s0 : (o1 ? s1 : 1'b0);
        e.slock = o0 ? l0 : (o1 ? l1 : 1'b0);
        e.swe   = o0;
        e.sadr  = o0 ? A0 : (o1 ? A1 : 32'h0);
        e.sdato = o0 ? D0 : (o1 ? D1 : 32'h0);
        e.a0 = a0; e.a1 = a1; e.e0 = e0; e.e1 = e1; e.irq = irq;
        e.d0 = o0 ? sdat : 32'h0;
        e.d1 = o1 ? sdat : 32'h0;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t  e, a;
            string n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            a = {grant, s_wb_CYC_O, s_wb_STB_O, s_wb_LOCK_O, s_wb_WE_O, s_wb_ADR_O,
                 s_wb_DAT_O, m0_wb_ACK_O, m1_wb_ACK_O, m0_wb_ERR_O, m1_wb_ERR_O,
                 timeout_irq, m0_wb_DAT_O, m1_wb_DAT_O};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", n, a, e);
            end
        end
    end

    initial begin
        // reset state, then single m0 transfer with slave ERR and ACK
        v("rst_idle", 1, 0,0,0, 0,0,0, 0,0,32'h0,        2'b00, 0,0,0,0,0);
        v("rst_req",  1, 1,1,0, 0,0,0, 1,0,32'h5,        2'b00, 0,0,0,0,0);
        v("a_arb",    0, 1,1,0, 0,0,0, 0,0,32'h0,        2'b00, 0,0,0,0,0);
        v("a_own",    0, 1,1,0, 0,0,0, 0,0,32'h0,        2'b01, 0,0,0,0,0);
        v("a_err",    0, 1,1,0, 0,0,0, 0,1,32'h0,        2'b01, 0,0,1,0,0);
        v("a_ack",    0, 1,1,0, 0,0,0, 1,0,32'hDEAD0001, 2'b01, 1,0,0,0,0);
        v("a_drop",   0, 0,0,0, 0,0,0, 0,0,32'h0,        2'b01, 0,0,0,0,0);
        v("a_idle",   0, 0,0,0, 0,0,0, 0,0,32'h0,        2'b00, 0,0,0,0,0);
        // simultaneous request after reset, back-to-back handover, lock hold
        v("b_rst",    1, 0,0,0, 0,0,0, 0,0,32'h0,        2'b00, 0,0,0,0,0);
        v("b_arb",    0, 1,1,0, 1,1,0, 0,0,32'h0,        2'b00, 0,0,0,0,0);
        v("b_m0",     0, 1,1,0, 1,1,0, 0,0,32'h0,        2'b01, 0,0,0,0,0);
        v("b_m0ack",  0, 1,1,0, 1,1,0, 1,0,32'h11,       2'b01, 1,0,0,0,0);
        v("b_m0drop", 0, 0,0,0, 1,1,0, 0,0,32'h0,        2'b01, 0,0,0,0,0);
        v("b_m1",     0, 0,0,0, 1,1,0, 0,0,32'h0,        2'b10, 0,0,0,0,0);
        v("b_m1ack",  0, 0,0,0, 1,1,0, 1,0,32'h22,       2'b10, 0,1,0,0,0);
        v("b_lock",   0, 1,1,0, 1,1,1, 0,0,32'h0,        2'b10, 0,0,0,0,0);
        v("b_lock1",  0, 1,1,0, 0,0,1, 0,0,32'h0,        2'b10, 0,0,0,0,0);
        v("b_lock2",  0, 1,1,0, 0,0,1, 0,0,32'h0,        2'b10, 0,0,0,0,0);
        v("b_unlock", 0, 1,1,0, 0,0,0, 0,0,32'h0,        2'b10, 0,0,0,0,0);
        v("b_m0b",    0, 1,1,0, 0,0,0, 0,0,32'h0,        2'b01, 0,0,0,0,0);
        v("b_m0back", 0, 1,1,0, 0,0,0, 1,0,32'h33,       2'b01, 1,0,0,0,0);
        v("b_drop",   0, 0,0,0, 0,0,0, 0,0,32'h0,        2'b01, 0,0,0,0,0);
        v("b_idle",   0, 0,0,0, 0,0,0, 0,0,32'h0,        2'b00, 0,0,0,0,0);
        // watchdog abort with TIMEOUT=4, late ACK discarded, m1 waits then wins
        v("c_arb",    0, 1,1,0, 0,0,0, 0,0,32'h0,        2'b00, 0,0,0,0,0);
        v("c_w1",     0, 1,1,0, 0,0,0, 0,0,32'h0,        2'b01, 0,0,0,0,0);
        v("c_w2",     0, 1,1,0, 0,0,0, 0,0,32'h0,        2'b01, 0,0,0,0,0);
        v("c_w3",     0, 1,1,0, 0,0,0, 0,0,32'h0,        2'b01, 0,0,0,0,0);
        v("c_w4",     0, 1,1,0, 0,0,0, 0,0,32'h0,        2'b01, 0,0,0,0,0);
        v("c_abort",  0, 1,1,0, 0,0,0, 1,0,32'h99,       2'b00, 0,0,1,0,1);
        v("c_hold",   0, 1,1,0, 1,1,0, 1,0,32'h98,       2'b00, 0,0,0,0,0);
        v("c_release",0, 0,0,0, 1,1,0, 0,0,32'h0,        2'b00, 0,0,0,0,0);
        v("c_m1",     0, 0,0,0, 1,1,0, 0,0,32'h0,        2'b10, 0,0,0,0,0);
        v("c_m1ack",  0, 0,0,0, 1,1,0, 1,0,32'h44,       2'b10, 0,1,0,0,0);
        v("c_m1drop", 0, 0,0,0, 0,0,0, 0,0,32'h0,        2'b10, 0,0,0,0,0);
        v("c_idle",   0, 0,0,0, 0,0,0, 0,0,32'h0,        2'b00, 0,0,0,0,0);
        // ACK in the threshold cycle wins over the timeout
        v("d_arb",    0, 1,1,0, 0,0,0, 0,0,32'h0,        2'b00, 0,0,0,0,0);
        v("d_w1",     0, 1,1,0, 0,0,0, 0,0,32'h0,        2'b01, 0,0,0,0,0);
        v("d_w2",     0, 1,1,0, 0,0,0, 0,0,32'h0,        2'b01, 0,0,0,0,0);
        v("d_w3",     0, 1,1,0, 0,0,0, 0,0,32'h0,        2'b01, 0,0,0,0,0);
        v("d_ackthr", 0, 1,1,0, 0,0,0, 1,0,32'h55,       2'b01, 1,0,0,0,0);
        v("d_drop",   0, 0,0,0, 0,0,0, 0,0,32'h0,        2'b01, 0,0,0,0,0);
        v("d_idle",   0, 0,0,0, 0,0,0, 0,0,32'h0,        2'b00, 0,0,0,0,0);
        // reset in the middle of an m1 read burst
        v("e_arb",    0, 0,0,0, 1,1,0, 0,0,32'h0,        2'b00, 0,0,0,0,0);
        v("e_m1",     0, 0,0,0, 1,1,0, 0,0,32'h0,        2'b10, 0,0,0,0,0);
        v("e_m1ack",  0, 0,0,0, 1,1,0, 1,0,32'h66,       2'b10, 0,1,0,0,0);
        v("e_rstmid", 1, 0,0,0, 1,1,0, 1,0,32'h67,       2'b00, 0,0,0,0,0);
        v("e_arb2",   0, 1,1,0, 1,1,0, 0,0,32'h0,        2'b00, 0,0,0,0,0);
        v("e_m0",     0, 1,1,0, 1,1,0, 0,0,32'h0,        2'b01, 0,0,0,0,0);
        v("e_m0ack",  0, 1,1,0, 1,1,0, 1,0,32'h77,       2'b01, 1,0,0,0,0);
        v("e_m0drop", 0, 0,0,0, 1,1,0, 0,0,32'h0,        2'b01, 0,0,0,0,0);
        v("e_m1b",    0, 0,0,0, 1,1,0, 0,0,32'h0,        2'b10, 0,0,0,0,0);
        v("e_m1back", 0, 0,0,0, 1,1,0, 1,0,32'h88,       2'b10, 0,1,0,0,0);
        v("e_m1drop", 0, 0,0,0, 0,0,0, 0,0,32'h0,        2'b10, 0,0,0,0,0);
        v("e_idle",   0, 0,0,0, 0,0,0, 0,0,32'h0,        2'b00, 0,0,0,0,0);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_wb_arbiter.md
VIDEO_WB_ARBITER -- requirements
Module: video_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: number of cycles a granted strobe may wait for ACK/ERR before it is aborted.
REQ-002 Parameter FIRST_PRIO, default 0: the master that wins the first arbitration after reset.
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 RST  in  1  reset, asynchronous and active-high.
REQ-005 mN_wb_CYC_I, mN_wb_STB_I, mN_wb_LOCK_I, mN_wb_WE_I  in  1 each  Wishbone master N request signals; N=0 is video_in_store (writes), N=1 is the video_out fetch (reads).
REQ-006 mN_wb_SEL_I  in  4;  mN_wb_ADR_I  in  32;  mN_wb_DAT_I  in  32  master N select, address and write data.
REQ-007 mN_wb_ACK_O, mN_wb_ERR_O  out  1 each;  mN_wb_DAT_O  out  32  responses and read data returned to master N.
REQ-008 s_wb_CYC_O, s_wb_STB_O, s_wb_LOCK_O, s_wb_WE_O  out  1;  s_wb_SEL_O  out  4;  s_wb_ADR_O, s_wb_DAT_O  out  32  shared slave-side port.
REQ-009 s_wb_ACK_I, s_wb_ERR_I  in  1;  s_wb_DAT_I  in  32  slave responses.
REQ-010 grant  out  2  current owner: 2'b00 none, 2'b01 master 0, 2'b10 master 1.
REQ-011 timeout_irq  out  1  one-cycle pulse each time a transfer is aborted.

Function
REQ-012 States SHALL be IDLE, OWN0, OWN1 and ABORT; `grant` SHALL be registered from the state.
REQ-013 In IDLE with exactly one CYC_I high, that master SHALL be granted on the next cycle, giving 1-cycle arbitration latency.
REQ-014 In IDLE with both CYC_I high, the master other than the last owner SHALL be granted (round-robin); before any grant, FIRST_PRIO wins.
REQ-015 While in OWNn, all slave outputs SHALL be driven combinationally from master n, and s_wb_ACK_I, s_wb_ERR_I and s_wb_DAT_I SHALL be routed only to master n.
REQ-016 The non-owner SHALL see ACK_O=0 and ERR_O=0 and may wait with CYC_I held high; its request is never lost.
REQ-017 The owner SHALL keep the grant while CYC_I=1, or while LOCK_I=1 even if CYC_I=0.
REQ-018 When the owner has CYC_I=0 and LOCK_I=0, the next state SHALL be the other master's OWN state if its CYC_I=1, otherwise IDLE, with no idle cycle between owners.
REQ-019 In IDLE and ABORT, s_wb_CYC_O, s_wb_STB_O, s_wb_LOCK_O and s_wb_WE_O SHALL be 0.
REQ-020 Watchdog counter: clears on any cycle where the owner has STB_I=0 or the slave returns ACK_I or ERR_I, and otherwise increments while STB_I=1.
REQ-021 When the watchdog counter reaches TIMEOUT, the next state SHALL be ABORT.
REQ-022 On ABORT entry, the aborted master SHALL receive ERR_O=1 for exactly one cycle and timeout_irq SHALL pulse for the same cycle.
REQ-023 ABORT SHALL hold until the aborted master drops CYC_I, then follow the REQ-018 rules.
REQ-024 A slave ACK_I arriving while in ABORT SHALL be discarded.
REQ-025 Watchdog counter width SHALL be $clog2(TIMEOUT+1); TIMEOUT=0 disables the watchdog.
REQ-026 When ACK_I and the timeout threshold occur in the same cycle, ACK SHALL win and the counter SHALL clear.

Reset
REQ-027 While RST=1: state=IDLE, grant=2'b00, last owner=1-FIRST_PRIO, watchdog counter=0, timeout_irq=0, all ACK_O/ERR_O=0, all slave control outputs=0.
REQ-028 Reset asserted mid-transfer SHALL drop s_wb_CYC_O asynchronously; the first grant after release follows REQ-013 and REQ-014.

Structure
REQ-029 Package video_pkg SHALL hold the state enum arb_state_t, the grant encodings and the default TIMEOUT constant.
REQ-030 Sub-module video_wb_watchdog SHALL contain the timeout counter, with inputs strobe, done and enable and output expired.

Verification
REQ-031 Only m0 requests, CYC/STB on cycle 0, slave ACK on cycle 3 -> grant=01 from cycle 1; m0_ACK_O on cycle 3; state IDLE after CYC drops.
REQ-032 m0 and m1 assert CYC in the same cycle after reset with FIRST_PRIO=0 -> m0 granted first; m1 granted the cycle after m0 drops CYC, with no IDLE cycle.
REQ-033 m1 holds LOCK=1 and drops CYC for 2 cycles while m0 is requesting -> grant stays 10 until m1 releases LOCK.
REQ-034 TIMEOUT=4, m0 strobes and the slave never responds -> ABORT after 4 cycles; m0_ERR_O and timeout_irq pulse once; s_wb_CYC_O=0.
REQ-035 ACK arrives in the same cycle the count reaches TIMEOUT -> normal ACK to the master, no timeout_irq.
REQ-036 RST pulsed during an m1 read burst -> all outputs at reset values within the same cycle; arbitration after reset resumes per REQ-014.
